// File: rtl/sprite_ram_arb.sv
// sprite_ram_arb
//
// Shares one sprite RAM port between the video pixel fetch path and a host
// writer. Host writes are granted only during blanking: a limited number of
// writes (WR_PER_LINE) per horizontal blank, and an unlimited number during
// vertical blank. A write is accepted in the same cycle it is granted; when no
// write is granted the RAM port carries the video read address.
//
// Optional feature: define SPRITE_ARB_STATS_EN to build a saturating counter
// of host stall cycles that clears at each frame start. Without the macro,
// stall_cnt_o is tied to zero and no counter is built.
//
// Ports
//   clk_i        single clock
//   rst_i        synchronous, active-high reset
//   cen_i        video clock enable; all state advances only when high
//   vh_blank_i   {Vblank, Hblank}
//   vid_addr_i   video read address
//   vid_data_o   registered pixel data back to the video path
//   host_req_i   host write request, held until host_ack_o
//   host_addr_i  host write address
//   host_data_i  host write data
//   host_ack_o   one-cycle write-accepted strobe
//   ram_addr_o   RAM address (host address on grant, video address otherwise)
//   ram_data_o   RAM write data
//   ram_we_o     RAM write enable
//   ram_data_i   RAM read data, one cycle after the address
//   frame_o      one-cycle pulse after Vblank rises
//   stall_cnt_o  host stall statistic (zero unless SPRITE_ARB_STATS_EN)

module sprite_ram_arb #(
    parameter int WR_PER_LINE = 8,
    parameter int ADDR_W      = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cen_i,
    input  logic [1:0]        vh_blank_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic [3:0]        vid_data_o,
    input  logic              host_req_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [3:0]        host_data_i,
    output logic              host_ack_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [3:0]        ram_data_o,
    output logic              ram_we_o,
    input  logic [3:0]        ram_data_i,
    output logic              frame_o,
    output logic [15:0]       stall_cnt_o
);

    localparam logic [7:0] BUDGET_INIT = 8'(WR_PER_LINE);

    typedef enum logic [1:0] {
        S_VIDEO  = 2'd0,
        S_HBLANK = 2'd1,
        S_LOCK   = 2'd2,
        S_VBLANK = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] budget_q, budget_d;
    logic       prev_vb_q;
    logic       prev_rd_q;
    logic       frame_q, frame_d;
    logic [3:0] vid_data_q;

    logic vblank;
    logic hblank;
    logic grant;

    assign vblank = vh_blank_i[1];
    assign hblank = vh_blank_i[0];

    // Grant looks at the live blank bits as well as the state, so a blank bit
    // dropping in the same cycle as a request never lets a write through into
    // active video.
    assign grant = cen_i & ~rst_i & host_req_i
                 & ((state_q == S_HBLANK) | (state_q == S_VBLANK))
                 & (vh_blank_i != 2'b00);

    assign ram_we_o   = grant;
    assign host_ack_o = grant;
    assign ram_addr_o = grant ? host_addr_i : vid_addr_i;
    assign ram_data_o = grant ? host_data_i : 4'h0;

    assign frame_d = vblank & ~prev_vb_q;

    always_comb begin
        state_d  = state_q;
        budget_d = budget_q;
        if (cen_i) begin
            // Every Hblank grant consumes budget, even one that coincides
            // with the move into Vblank.
            if ((state_q == S_HBLANK) && grant) begin
                budget_d = budget_q - 8'd1;
            end
            case (state_q)
                S_VIDEO: begin
                    if (vblank) begin
                        state_d = S_VBLANK;
                    end else if (hblank) begin
                        state_d  = S_HBLANK;
                        budget_d = BUDGET_INIT;
                    end
                end
                S_HBLANK: begin
                    if (vblank) begin
                        state_d = S_VBLANK;
                    end else if (!hblank) begin
                        state_d = S_VIDEO;
                    end else if (grant && (budget_q == 8'd1)) begin
                        state_d = S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (vblank) begin
                        state_d = S_VBLANK;
                    end else if (!hblank) begin
                        state_d = S_VIDEO;
                    end
                end
                S_VBLANK: begin
                    if (!vblank) begin
                        if (hblank) begin
                            state_d  = S_HBLANK;
                            budget_d = BUDGET_INIT;
                        end else begin
                            state_d = S_VIDEO;
                        end
                    end
                end
                default: state_d = S_VIDEO;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_VIDEO;
            budget_q   <= 8'd0;
            prev_vb_q  <= 1'b0;
            prev_rd_q  <= 1'b0;
            frame_q    <= 1'b0;
            vid_data_q <= 4'h0;
        end else if (cen_i) begin
            state_q   <= state_d;
            budget_q  <= budget_d;
            prev_vb_q <= vblank;
            frame_q   <= frame_d;
            // RAM data now on ram_data_i belongs to the previous enabled
            // cycle; only take it if that cycle was a video read.
            if (prev_rd_q) begin
                vid_data_q <= ram_data_i;
            end
            prev_rd_q <= ~grant;
        end
    end

    assign vid_data_o = vid_data_q;
    assign frame_o    = frame_q;

`ifdef SPRITE_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Clears on the same edge that raises frame_o, so the count reads zero
    // while frame_o is high.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (frame_d) begin
            stall_cnt_d = 16'h0000;
        end else if (host_req_i && !grant && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 16'h0000;
        end else if (cen_i) begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_sprite_ram_arb.sv
module tb_sprite_ram_arb;

    localparam int WR_PER_LINE = 8;
    localparam int ADDR_W      = 15;

`ifdef SPRITE_ARB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    localparam int M_ACTIVE = 0;
    localparam int M_HB     = 1;
    localparam int M_LOCK   = 2;
    localparam int M_VB     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              cen;
    logic [1:0]        vh;
    logic [ADDR_W-1:0] vid_addr;
    logic [3:0]        vid_data;
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic [3:0]        host_data;
    logic              host_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_wdata;
    logic              ram_we;
    logic [3:0]        ram_rdata = 4'h0;
    logic              frame;
    logic [15:0]       stall_cnt;

    int n_run  = 0;
    int n_fail = 0;

    sprite_ram_arb #(.WR_PER_LINE(WR_PER_LINE), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cen_i       (cen),
        .vh_blank_i  (vh),
        .vid_addr_i  (vid_addr),
        .vid_data_o  (vid_data),
        .host_req_i  (host_req),
        .host_addr_i (host_addr),
        .host_data_i (host_data),
        .host_ack_o  (host_ack),
        .ram_addr_o  (ram_addr),
        .ram_data_o  (ram_wdata),
        .ram_we_o    (ram_we),
        .ram_data_i  (ram_rdata),
        .frame_o     (frame),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    // Sprite RAM stand-in: 16 words aliased on the low address bits,
    // read-first, one cycle read latency.
    logic [3:0] mem [0:15];
    logic       ram_clear = 1'b1;
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr[3:0]];
        if (ram_clear) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'(i * 7 + 3);
        end else if (ram_we) begin
            mem[ram_addr[3:0]] <= ram_wdata;
        end
    end

    // Reference model
    int         m_state = M_ACTIVE;
    int         m_budget = 0;
    bit         m_pvb = 1'b0;
    bit         m_lastrd = 1'b0;
    logic [3:0] m_vd = 4'h0;
    bit         m_frame = 1'b0;
    int         m_stall = 0;
    logic [3:0] m_rdval = 4'h0;
    logic [3:0] mmem [0:15];

    bit                exp_g;
    logic [ADDR_W-1:0] exp_addr;
    logic [3:0]        exp_wdata;
    logic [15:0]       exp_stall;

    function automatic bit model_grant();
        return cen && !rst && host_req && (m_state == M_HB || m_state == M_VB) && (vh != 2'b00);
    endfunction

    task automatic model_edge();
        bit                g;
        bit                rise;
        int                old_budget;
        logic [ADDR_W-1:0] a;
        g = model_grant();
        a = g ? host_addr : vid_addr;
        if (rst) begin
            m_state = M_ACTIVE; m_budget = 0; m_pvb = 0; m_lastrd = 0;
            m_vd = 4'h0; m_frame = 0; m_stall = 0;
        end else if (cen) begin
            rise = vh[1] && !m_pvb;
            if (m_lastrd) m_vd = m_rdval;
            m_lastrd = !g;
            if (rise) m_stall = 0;
            else if (host_req && !g && m_stall < 65535) m_stall++;
            m_frame = rise;
            m_pvb = vh[1];
            old_budget = m_budget;
            if (m_state == M_HB && g) m_budget = old_budget - 1;
            case (m_state)
                M_ACTIVE: if (vh[1]) m_state = M_VB;
                          else if (vh[0]) begin m_state = M_HB; m_budget = WR_PER_LINE; end
                M_HB:     if (vh[1]) m_state = M_VB;
                          else if (!vh[0]) m_state = M_ACTIVE;
                          else if (g && old_budget == 1) m_state = M_LOCK;
                M_LOCK:   if (vh[1]) m_state = M_VB;
                          else if (!vh[0]) m_state = M_ACTIVE;
                default:  if (!vh[1]) begin
                              if (vh[0]) begin m_state = M_HB; m_budget = WR_PER_LINE; end
                              else m_state = M_ACTIVE;
                          end
            endcase
        end
        m_rdval = mmem[a[3:0]];
        if (g) mmem[a[3:0]] = host_data;
        exp_stall = (STATS != 0) ? 16'(m_stall) : 16'h0000;
    endtask

    task automatic drive(input bit r, input bit c, input logic [1:0] b, input bit q);
        rst       = r;
        cen       = c;
        vh        = b;
        host_req  = q;
        vid_addr  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
        host_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
        host_data = 4'($urandom_range(0, 15));
    endtask

    task automatic settle();
        #1;
        exp_g     = model_grant();
        exp_addr  = exp_g ? host_addr : vid_addr;
        exp_wdata = exp_g ? host_data : 4'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 2'b11, 1);
            settle();
            n_run++;
            if (host_ack !== 1'b0 || ram_we !== 1'b0) begin
                n_fail++; $display("FAIL reset_ack: ack=%b we=%b required 0 0", host_ack, ram_we);
            end
            tick();
            ram_clear = 1'b0;
            n_run++;
            if (vid_data !== 4'h0 || frame !== 1'b0 || stall_cnt !== 16'h0) begin
                n_fail++; $display("FAIL reset_regs: vid=%h frame=%b stall=%h required 0 0 0", vid_data, frame, stall_cnt);
            end
        end
        drive(0, 1, 2'b00, 0); settle(); tick();
    endtask

    task automatic test_hblank_budget();
        int acks = 0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 2'b00, 1); settle();
            n_run++;
            if (ram_we !== 1'b0 || host_ack !== 1'b0 || ram_addr !== vid_addr) begin
                n_fail++; $display("FAIL active_no_write: we=%b ack=%b addr=%h required 0 0 %h", ram_we, host_ack, ram_addr, vid_addr);
            end
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 2'b01, 1); settle();
            n_run++;
            if (host_ack !== exp_g || ram_we !== exp_g) begin
                n_fail++; $display("FAIL hb_ack cyc %0d: ack=%b we=%b required %b", i, host_ack, ram_we, exp_g);
            end
            if (exp_g) begin
                n_run++;
                if (ram_addr !== exp_addr || ram_wdata !== exp_wdata) begin
                    n_fail++; $display("FAIL hb_port cyc %0d: addr=%h data=%h required %h %h", i, ram_addr, ram_wdata, exp_addr, exp_wdata);
                end
            end
            if (host_ack === 1'b1) acks++;
            tick();
        end
        n_run++;
        if (acks != WR_PER_LINE) begin
            n_fail++; $display("FAIL hb_count: acks=%0d required %0d", acks, WR_PER_LINE);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 2'b00, 1); settle();
            n_run++;
            if (ram_we !== 1'b0 || ram_addr !== vid_addr) begin
                n_fail++; $display("FAIL hb_after: we=%b addr=%h required 0 %h", ram_we, ram_addr, vid_addr);
            end
            tick();
        end
    endtask

    task automatic test_vblank();
        int acks = 0;
        int frames = 0;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 2'b01, 0); settle(); tick();
        end
        for (int i = 0; i < 100; i++) begin
            drive(0, 1, 2'b10, 1); settle();
            n_run++;
            if (host_ack !== exp_g) begin
                n_fail++; $display("FAIL vb_ack cyc %0d: ack=%b required %b", i, host_ack, exp_g);
            end
            if (host_ack === 1'b1) acks++;
            tick();
            if (frame === 1'b1) frames++;
        end
        n_run++;
        if (acks != 100) begin
            n_fail++; $display("FAIL vb_count: acks=%0d required 100", acks);
        end
        n_run++;
        if (frames != 1) begin
            n_fail++; $display("FAIL vb_frame: pulses=%0d required 1", frames);
        end
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 2'b01, 1); settle();
            if (host_ack === 1'b1) acks++;
            tick();
        end
        n_run++;
        if (acks != 1 + WR_PER_LINE) begin
            n_fail++; $display("FAIL vb_to_hb: acks=%0d required %0d", acks, 1 + WR_PER_LINE);
        end
    endtask

    task automatic test_blank_fall();
        drive(0, 1, 2'b00, 0); settle(); tick();
        drive(0, 1, 2'b01, 0); settle(); tick();
        drive(0, 1, 2'b01, 0); settle(); tick();
        drive(0, 1, 2'b00, 1); settle();
        n_run++;
        if (ram_we !== 1'b0 || host_ack !== 1'b0 || ram_addr !== vid_addr) begin
            n_fail++; $display("FAIL blank_fall: we=%b ack=%b addr=%h required 0 0 %h", ram_we, host_ack, ram_addr, vid_addr);
        end
        tick();
        drive(0, 1, 2'b01, 1); settle();
        n_run++;
        if (host_ack !== 1'b0) begin
            n_fail++; $display("FAIL pending_reentry: ack=%b required 0", host_ack);
        end
        tick();
        drive(0, 1, 2'b01, 1); settle();
        n_run++;
        if (host_ack !== 1'b1 || ram_addr !== host_addr) begin
            n_fail++; $display("FAIL pending_grant: ack=%b addr=%h required 1 %h", host_ack, ram_addr, host_addr);
        end
        tick();
        drive(0, 1, 2'b00, 0); settle(); tick();
    endtask

    task automatic test_reset_midwrite();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 2'b10, 1); settle(); tick();
        end
        drive(0, 1, 2'b10, 1); settle();
        n_run++;
        if (host_ack !== 1'b1) begin
            n_fail++; $display("FAIL burst_ack: ack=%b required 1", host_ack);
        end
        tick();
        drive(1, 1, 2'b10, 1); settle();
        n_run++;
        if (host_ack !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_write: ack=%b we=%b required 0 0", host_ack, ram_we);
        end
        tick();
        drive(0, 1, 2'b10, 1); vid_addr = '0; settle();
        n_run++;
        if (host_ack !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== 4'h0
            || vid_data !== 4'h0 || frame !== 1'b0 || stall_cnt !== 16'h0) begin
            n_fail++; $display("FAIL rst_outputs: ack=%b we=%b addr=%h wd=%h vid=%h frame=%b stall=%h required all 0",
                               host_ack, ram_we, ram_addr, ram_wdata, vid_data, frame, stall_cnt);
        end
        tick();
        n_run++;
        if (frame !== 1'b1) begin
            n_fail++; $display("FAIL rst_frame: frame=%b required 1", frame);
        end
        drive(0, 1, 2'b10, 1); settle();
        n_run++;
        if (host_ack !== 1'b1) begin
            n_fail++; $display("FAIL rst_regrant: ack=%b required 1", host_ack);
        end
        tick();
        drive(0, 1, 2'b00, 0); settle(); tick();
    endtask

    task automatic test_cen_toggle();
        int acks = 0;
        drive(0, 1, 2'b00, 1); settle(); tick();
        for (int i = 0; i < 30; i++) begin
            drive(0, (i % 2) == 0, 2'b01, 1); settle();
            n_run++;
            if (host_ack !== exp_g || (!cen && host_ack !== 1'b0)) begin
                n_fail++; $display("FAIL cen_ack cyc %0d: cen=%b ack=%b required %b", i, cen, host_ack, exp_g);
            end
            if (host_ack === 1'b1) acks++;
            tick();
            n_run++;
            if (vid_data !== m_vd || frame !== m_frame) begin
                n_fail++; $display("FAIL cen_hold cyc %0d: vid=%h frame=%b required %h %b", i, vid_data, frame, m_vd, m_frame);
            end
        end
        n_run++;
        if (acks != WR_PER_LINE) begin
            n_fail++; $display("FAIL cen_count: acks=%0d required %0d", acks, WR_PER_LINE);
        end
        drive(0, 1, 2'b00, 0); settle(); tick();
    endtask

    task automatic test_stats();
        drive(1, 1, 2'b00, 0); settle(); tick();
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 2'b00, 1); settle(); tick();
        end
        n_run++;
        if (stall_cnt !== 16'(STATS * 300) || frame !== 1'b0) begin
            n_fail++; $display("FAIL stats_count: stall=%0d frame=%b required %0d 0", stall_cnt, frame, STATS * 300);
        end
        drive(0, 1, 2'b10, 1); settle(); tick();
        n_run++;
        if (frame !== 1'b1 || stall_cnt !== 16'h0) begin
            n_fail++; $display("FAIL stats_clear: frame=%b stall=%0d required 1 0", frame, stall_cnt);
        end
        drive(0, 1, 2'b10, 1); settle(); tick();
        n_run++;
        if (frame !== 1'b0 || stall_cnt !== 16'h0) begin
            n_fail++; $display("FAIL stats_after: frame=%b stall=%0d required 0 0", frame, stall_cnt);
        end
    endtask

    task automatic test_random();
        logic [1:0] b;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    b = 2'b00;
                2, 3:    b = 2'b01;
                4:       b = 2'b10;
                default: b = 2'b11;
            endcase
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, b, $urandom_range(0, 3) != 0);
            settle();
            n_run++;
            if (host_ack !== exp_g || ram_we !== exp_g || ram_addr !== exp_addr
                || (exp_g && ram_wdata !== exp_wdata)) begin
                n_fail++; $display("FAIL rnd_port cyc %0d: ack=%b we=%b addr=%h wd=%h required %b %b %h %h",
                                   i, host_ack, ram_we, ram_addr, ram_wdata, exp_g, exp_g, exp_addr, exp_wdata);
            end
            tick();
            n_run++;
            if (vid_data !== m_vd || frame !== m_frame || stall_cnt !== exp_stall) begin
                n_fail++; $display("FAIL rnd_regs cyc %0d: vid=%h frame=%b stall=%0d required %h %b %0d",
                                   i, vid_data, frame, stall_cnt, m_vd, m_frame, exp_stall);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mmem[i] = 4'(i * 7 + 3);
        exp_stall = 16'h0;
        test_reset();
        test_hblank_budget();
        test_vblank();
        test_blank_fall();
        test_reset_midwrite();
        test_cen_toggle();
        test_stats();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_ram_arb.md
SPRITE_RAM_ARB -- requirements
Module: sprite_ram_arb

Interface
REQ-001 SHALL have parameter WR_PER_LINE, default 8, which sets the maximum host writes granted per horizontal blank (range 1..255).
REQ-002 SHALL have parameter ADDR_W, default 15, which sets the sprite RAM address width.
REQ-003 clk_i  in  1  clock; the block SHALL use this single clock.
REQ-004 rst_i  in  1  reset; SHALL be synchronous and active-high.
REQ-005 cen_i  in  1  video clock enable; state, counters and grants SHALL advance only when cen_i=1.
REQ-006 vh_blank_i  in  2  {Vblank, Hblank}.
REQ-007 vid_addr_i  in  ADDR_W  pixel read address from the video path.
REQ-008 vid_data_o  out  4  pixel read data to the video path.
REQ-009 host_req_i  in  1  host write request; held until acknowledged.
REQ-010 host_addr_i  in  ADDR_W  host write address.
REQ-011 host_data_i  in  4  host write data.
REQ-012 host_ack_o  out  1  one-cycle write-accepted strobe.
REQ-013 ram_addr_o / ram_data_o / ram_we_o  out  ADDR_W/4/1  port to the sprite RAM.
REQ-014 ram_data_i  in  4  RAM read data, with 1-cycle read latency.
REQ-015 frame_o  out  1  one-cycle pulse on the Vblank rising edge.
REQ-016 stall_cnt_o  out  16  host stall statistic (see Configuration).

Function
REQ-017 The FSM SHALL have states S_VIDEO, S_HBLANK, S_LOCK and S_VBLANK; transitions SHALL be registered and SHALL occur only when cen_i=1.
REQ-018 From S_VIDEO: if Vblank=1 then S_VBLANK; else if Hblank=1 then S_HBLANK, with budget loaded to WR_PER_LINE.
REQ-019 From S_HBLANK: if Vblank=1 then S_VBLANK; else if Hblank=0 then S_VIDEO; else if a grant occurs with budget=1 then S_LOCK.
REQ-020 From S_LOCK: if Vblank=1 then S_VBLANK; else if Hblank=0 then S_VIDEO.
REQ-021 From S_VBLANK: if Vblank=0 and Hblank=1 then S_HBLANK with fresh budget; if Vblank=0 and Hblank=0 then S_VIDEO.
REQ-022 grant SHALL be combinational: cen_i & ~rst_i & host_req_i & (state is S_HBLANK or S_VBLANK) & (current vh_blank_i != 0).
REQ-023 When grant=1, ram_we_o=1, ram_addr_o=host_addr_i, ram_data_o=host_data_i and host_ack_o=1, all in the same cycle (zero latency).
REQ-024 When grant=0, ram_we_o=0 and ram_addr_o=vid_addr_i.
REQ-025 The video path SHALL never be displaced during active video; a blank bit falling in the same cycle as a request SHALL block the grant.
REQ-026 Each grant in S_HBLANK SHALL decrement the 8-bit budget; grants in S_VBLANK SHALL be unlimited and SHALL not touch the budget.
REQ-027 vid_data_o SHALL register ram_data_i on cen_i when the previous enabled cycle was a read, and SHALL hold its value after a write cycle.
REQ-028 frame_o SHALL be registered: 1 for one cen cycle after the cycle in which Vblank goes 0->1.
REQ-029 With cen_i=0: grant=0, and state, budget, vid_data_o and frame_o SHALL hold.

Reset
REQ-030 With rst_i=1 at a clock edge: state=S_VIDEO, budget=0, vid_data_o=0, frame_o=0, stall_cnt_o=0, previous-blank registers=0.
REQ-031 With rst_i=1 mid-write: ram_we_o and host_ack_o SHALL be 0 in that same cycle.
REQ-032 After reset the first grant SHALL require a fresh blank entry.

Configuration
REQ-033 Macro SPRITE_ARB_STATS_EN defined: stall_cnt_o SHALL count cen cycles with host_req_i=1 & grant=0, saturate at 16'hFFFF, and clear on frame_o.
REQ-034 Macro SPRITE_ARB_STATS_EN undefined: stall_cnt_o SHALL be constant 0 and no counter logic SHALL be generated.

Verification
REQ-035 Hblank high for 20 cycles with host_req_i held -> exactly 8 host_ack_o pulses, then S_LOCK, with no ram_we_o during active video.
REQ-036 Vblank high for 100 cycles with continuous requests -> 100 acks; on Vblank 0 with Hblank 1 -> S_HBLANK, budget 8.
REQ-037 Hblank falls in the same cycle as a request -> ram_we_o=0, ram_addr_o=vid_addr_i, host request stays pending.
REQ-038 rst_i asserted during S_VBLANK write burst -> ack drops the same cycle; all outputs 0 next cycle; state S_VIDEO.
REQ-039 cen_i toggling 1/0 during Hblank -> acks only on cen_i=1 cycles, and budget counts only granted cycles.
REQ-040 Stats build, 300 stalled cycles then Vblank rise -> stall_cnt_o=300 before frame_o, then 0; non-stats build -> stall_cnt_o=0 throughout.
